// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: 8259A-style mask/priority resolve, 8086 two-pulse INTA handshake and EOI handling; define AUTO_ROTATE_EN for automatic priority rotation
module interrupt_ack_sequencer #(
  parameter int         NUM_IR         = 8,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_IR-1:0] Int_Req_Reg,
  input  logic [NUM_IR-1:0] Int_Mask,
  input  logic [4:0]        Vector_Base,
  input  logic              Auto_EOI,
  input  logic              INTA_n,
  input  logic              Non_Specific_EOI,
  input  logic              Specific_EOI,
  input  logic [2:0]        EOI_Level,
  output logic              INT,
  output logic [NUM_IR-1:0] Clear_IRR,
  output logic [NUM_IR-1:0] In_Service_Reg,
  output logic [7:0]        Data_Out,
  output logic              Data_Out_En
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACK1  = 2'd1;
  localparam logic [1:0] WAIT2 = 2'd2;
  localparam logic [1:0] ACK2  = 2'd3;
  // Highest-priority set bit of v, where priority starts just above lowest-priority level p; returns {found, level}
  function automatic logic [3:0] first_set(input logic [7:0] v, input logic [2:0] p);
    logic [2:0] k;
    first_set = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'd1 + 3'(i);
      if (v[k]) first_set = {1'b1, k};
    end
  endfunction
  logic [1:0] state_q, state_d;
  logic       inta_q, int_q, int_d, spur_q, spur_d, en_q, en_d;
  logic [2:0] lvl_q, lvl_d, ptr, prank, irank;
  logic [7:0] isr_q, isr_d, clr_q, clr_d, dout_q, dout_d;
  logic [7:0] pend, set_v, eoi_clr, aeoi_clr;
  logic [3:0] pw, iw;
  logic       fall, rise, qualify;
  assign fall = inta_q & ~INTA_n;
  assign rise = ~inta_q & INTA_n;
  assign pend = Int_Req_Reg & ~Int_Mask;
  assign pw = first_set(pend, ptr);
  assign iw = first_set(isr_q, ptr);
  // Ranks are distances from the top of the (possibly rotated) order, so smaller wins
  assign prank = pw[2:0] - ptr - 3'd1;
  assign irank = iw[2:0] - ptr - 3'd1;
  assign qualify = pw[3] & (~iw[3] | (prank < irank));
  assign eoi_clr = Specific_EOI ? 8'd1 << EOI_Level :
                   (Non_Specific_EOI & iw[3]) ? 8'd1 << iw[2:0] : 8'd0;
  // The ACK1 set is OR-ed in last so it beats any same-cycle clear of that bit
  assign isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | set_v;
`ifdef AUTO_ROTATE_EN
  logic [2:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
  assign ptr_d = Specific_EOI ? EOI_Level :
                 (Non_Specific_EOI & iw[3]) ? iw[2:0] :
                 (|aeoi_clr) ? lvl_q : ptr_q;
  // Lowest-priority pointer follows the most recently retired level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 3'd7;
    else          ptr_q <= ptr_d;
  end
`else
  assign ptr = 3'd7;
`endif
  // INTA handshake sequencing, vector drive and auto-EOI
  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    spur_d   = spur_q;
    set_v    = 8'd0;
    clr_d    = 8'd0;
    dout_d   = dout_q;
    en_d     = en_q;
    aeoi_clr = 8'd0;
    int_d    = qualify;
    case (state_q)
      IDLE: if (fall) begin
        state_d = ACK1;
        int_d   = 1'b0;
        lvl_d   = qualify ? pw[2:0] : SPURIOUS_LEVEL;
        spur_d  = ~qualify;
        set_v   = qualify ? 8'd1 << pw[2:0] : 8'd0;
        clr_d   = set_v;
      end
      ACK1: if (rise) state_d = WAIT2;
      WAIT2: if (fall) begin
        state_d = ACK2;
        dout_d  = {Vector_Base, lvl_q};
        en_d    = 1'b1;
      end
      default: if (rise) begin
        state_d  = IDLE;
        dout_d   = 8'd0;
        en_d     = 1'b0;
        aeoi_clr = (Auto_EOI & ~spur_q) ? 8'd1 << lvl_q : 8'd0;
      end
    endcase
  end
  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      inta_q  <= 1'b1;
      int_q   <= 1'b0;
      lvl_q   <= 3'd0;
      spur_q  <= 1'b0;
      isr_q   <= 8'd0;
      clr_q   <= 8'd0;
      dout_q  <= 8'd0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      inta_q  <= INTA_n;
      int_q   <= int_d;
      lvl_q   <= lvl_d;
      spur_q  <= spur_d;
      isr_q   <= isr_d;
      clr_q   <= clr_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
    end
  end
  assign INT            = int_q;
  assign Clear_IRR      = clr_q;
  assign In_Service_Reg = isr_q;
  assign Data_Out       = dout_q;
  assign Data_Out_En    = en_q;
endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// tb_interrupt_ack_sequencer: randomized and directed checks against a priority-list reference model
module tb_interrupt_ack_sequencer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] Int_Req_Reg, Int_Mask;
  logic [4:0] Vector_Base;
  logic       Auto_EOI, INTA_n, Non_Specific_EOI, Specific_EOI;
  logic [2:0] EOI_Level;
  logic       INT, Data_Out_En;
  logic [7:0] Clear_IRR, In_Service_Reg, Data_Out;
  int total = 0;
  int bad = 0;
  logic [7:0] m_isr;
  int         m_ptr;
  logic [7:0] c1, c2, i1, v, ie, de;
  logic       n1, e2, ee;

  interrupt_ack_sequencer dut (
    .clk(clk), .reset_n(reset_n), .Int_Req_Reg(Int_Req_Reg), .Int_Mask(Int_Mask),
    .Vector_Base(Vector_Base), .Auto_EOI(Auto_EOI), .INTA_n(INTA_n),
    .Non_Specific_EOI(Non_Specific_EOI), .Specific_EOI(Specific_EOI), .EOI_Level(EOI_Level),
    .INT(INT), .Clear_IRR(Clear_IRR), .In_Service_Reg(In_Service_Reg),
    .Data_Out(Data_Out), .Data_Out_En(Data_Out_En)
  );

  always #5 clk = ~clk;

  // Reference model: priority rank 0 is the level just after the lowest-priority pointer
  function automatic int rnk(int k);
    return (k - m_ptr - 1 + 16) % 8;
  endfunction
  function automatic int best(logic [7:0] x);
    int b = -1;
    for (int k = 0; k < 8; k++) if (x[k] && (b < 0 || rnk(k) < rnk(b))) b = k;
    return b;
  endfunction
  function automatic int m_win();
    int p = best(Int_Req_Reg & ~Int_Mask);
    int s = best(m_isr);
    return (p >= 0 && (s < 0 || rnk(p) < rnk(s))) ? p : -1;
  endfunction
  function automatic void m_clear(int k);
    m_isr[k] = 1'b0;
`ifdef AUTO_ROTATE_EN
    m_ptr = k;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two-pulse INTA sequence; records what the DUT showed at each stage
  task automatic handshake(output logic [7:0] o_c1, o_c2, o_i1, o_v, o_ie, o_de, output logic o_n1, o_e2, o_ee);
    INTA_n = 1'b0; step();
    o_c1 = Clear_IRR; o_i1 = In_Service_Reg; o_n1 = INT;
    step();
    o_c2 = Clear_IRR;
    INTA_n = 1'b1; step();
    INTA_n = 1'b0; step();
    o_v = Data_Out; o_e2 = Data_Out_En;
    INTA_n = 1'b1; step();
    o_ie = In_Service_Reg; o_de = Data_Out; o_ee = Data_Out_En;
  endtask

  task automatic pulse_eoi(input logic spec, input logic ns, input logic [2:0] lvl);
    Specific_EOI = spec; Non_Specific_EOI = ns; EOI_Level = lvl;
    step();
    Specific_EOI = 1'b0; Non_Specific_EOI = 1'b0;
    if (spec) m_clear(lvl);
    else if (ns && best(m_isr) >= 0) m_clear(best(m_isr));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; INTA_n = 1'b1; Int_Req_Reg = 8'h00; Int_Mask = 8'h00;
    Vector_Base = 5'd0; Auto_EOI = 1'b0; Non_Specific_EOI = 1'b0; Specific_EOI = 1'b0; EOI_Level = 3'd0;
    m_isr = 8'h00; m_ptr = 7;
    step(); step();
    reset_n = 1'b1; step();
    total++; if ({INT, Clear_IRR, In_Service_Reg, Data_Out, Data_Out_En} !== 26'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {INT, Clear_IRR, In_Service_Reg, Data_Out, Data_Out_En}); end
  endtask

  task automatic test_single();
    Vector_Base = 5'b00001; Int_Req_Reg = 8'h08; Int_Mask = 8'h00; Auto_EOI = 1'b0;
    step();
    total++; if (INT !== 1'b1) begin bad++; $display("FAIL single_int got=%b exp=1", INT); end
    handshake(c1, c2, i1, v, ie, de, n1, e2, ee);
    m_isr = 8'h08;
    total++; if (c1 !== 8'h08) begin bad++; $display("FAIL single_clr got=%h exp=08", c1); end
    total++; if (c2 !== 8'h00) begin bad++; $display("FAIL single_clr_width got=%h exp=00", c2); end
    total++; if (i1 !== 8'h08) begin bad++; $display("FAIL single_isr1 got=%h exp=08", i1); end
    total++; if (n1 !== 1'b0) begin bad++; $display("FAIL single_int_drop got=%b exp=0", n1); end
    total++; if (v !== 8'h0B || e2 !== 1'b1) begin bad++; $display("FAIL single_vec got=%h/%b exp=0b/1", v, e2); end
    total++; if (ee !== 1'b0 || de !== 8'h00) begin bad++; $display("FAIL single_release got=%h/%b exp=00/0", de, ee); end
    total++; if (ie !== 8'h08) begin bad++; $display("FAIL single_isr_end got=%h exp=08", ie); end
  endtask

  task automatic test_nesting();
    Int_Req_Reg = 8'h10; step();
    total++; if (INT !== 1'b0) begin bad++; $display("FAIL nest_block got=%b exp=0", INT); end
    Int_Req_Reg = 8'h02; step();
    total++; if (INT !== 1'b1) begin bad++; $display("FAIL nest_int got=%b exp=1", INT); end
    handshake(c1, c2, i1, v, ie, de, n1, e2, ee);
    m_isr = 8'h0A;
    total++; if (c1 !== 8'h02) begin bad++; $display("FAIL nest_clr got=%h exp=02", c1); end
    total++; if (v !== 8'h09) begin bad++; $display("FAIL nest_vec got=%h exp=09", v); end
    total++; if (ie !== 8'h0A) begin bad++; $display("FAIL nest_isr got=%h exp=0a", ie); end
    Int_Req_Reg = 8'h00;
    pulse_eoi(1'b0, 1'b1, 3'd0);
    total++; if (In_Service_Reg !== 8'h08) begin bad++; $display("FAIL nest_nseoi got=%h exp=08", In_Service_Reg); end
    pulse_eoi(1'b1, 1'b1, 3'd3);
    total++; if (In_Service_Reg !== 8'h00) begin bad++; $display("FAIL nest_seoi_wins got=%h exp=00", In_Service_Reg); end
    pulse_eoi(1'b0, 1'b1, 3'd0);
    total++; if (In_Service_Reg !== 8'h00) begin bad++; $display("FAIL nest_nseoi_empty got=%h exp=00", In_Service_Reg); end
  endtask

  task automatic test_aeoi_mask();
    Vector_Base = 5'b10110; Auto_EOI = 1'b1; Int_Req_Reg = 8'h81; Int_Mask = 8'h01;
    step();
    handshake(c1, c2, i1, v, ie, de, n1, e2, ee);
    m_clear(7);
    total++; if (c1 !== 8'h80 || i1 !== 8'h80) begin bad++; $display("FAIL aeoi_ack1 got=%h/%h exp=80/80", c1, i1); end
    total++; if (v !== 8'hB7) begin bad++; $display("FAIL aeoi_vec got=%h exp=b7", v); end
    total++; if (ie !== 8'h00) begin bad++; $display("FAIL aeoi_isr got=%h exp=00", ie); end
    Auto_EOI = 1'b0; Int_Mask = 8'h00; Int_Req_Reg = 8'h00;
  endtask

  task automatic test_spurious();
    Vector_Base = 5'b01010; Int_Req_Reg = 8'h08; step();
    Int_Req_Reg = 8'h00;
    handshake(c1, c2, i1, v, ie, de, n1, e2, ee);
    total++; if (c1 !== 8'h00) begin bad++; $display("FAIL spur_clr got=%h exp=00", c1); end
    total++; if (v !== 8'h57 || e2 !== 1'b1) begin bad++; $display("FAIL spur_vec got=%h/%b exp=57/1", v, e2); end
    total++; if (i1 !== m_isr || ie !== m_isr) begin bad++; $display("FAIL spur_isr got=%h/%h exp=%h", i1, ie, m_isr); end
  endtask

  task automatic test_reset_mid_ack2();
    Vector_Base = 5'b11100; Int_Req_Reg = 8'h20; step();
    INTA_n = 1'b0; step();
    INTA_n = 1'b1; step();
    INTA_n = 1'b0; step();
    total++; if (Data_Out_En !== 1'b1) begin bad++; $display("FAIL rst_ack2_en got=%b exp=1", Data_Out_En); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({INT, Clear_IRR, In_Service_Reg, Data_Out, Data_Out_En} !== 26'd0) begin bad++; $display("FAIL rst_async got=%h exp=0", {INT, Clear_IRR, In_Service_Reg, Data_Out, Data_Out_En}); end
    INTA_n = 1'b1; step();
    reset_n = 1'b1; m_isr = 8'h00; m_ptr = 7;
    step();
    total++; if (INT !== 1'b1) begin bad++; $display("FAIL rst_int_again got=%b exp=1", INT); end
    handshake(c1, c2, i1, v, ie, de, n1, e2, ee);
    m_isr = 8'h20;
    total++; if (c1 !== 8'h20 || v !== 8'hE5 || ie !== 8'h20) begin bad++; $display("FAIL rst_handshake got=%h/%h/%h exp=20/e5/20", c1, v, ie); end
    Int_Req_Reg = 8'h00;
    pulse_eoi(1'b1, 1'b0, 3'd5);
  endtask

  task automatic serve_and_eoi(input logic [7:0] req, input logic [7:0] exp_clr, input string tag);
    int w;
    Int_Req_Reg = req; step();
    w = m_win();
    handshake(c1, c2, i1, v, ie, de, n1, e2, ee);
    total++; if (c1 !== exp_clr) begin bad++; $display("FAIL %s got=%h exp=%h", tag, c1, exp_clr); end
    total++; if (w < 0 || c1 !== (8'd1 << w)) begin bad++; $display("FAIL %s_model got=%h model_level=%0d", tag, c1, w); end
    Int_Req_Reg = 8'h00;
    if (w >= 0) begin
      m_isr[w] = 1'b1;
      pulse_eoi(1'b1, 1'b0, 3'(w));
    end
    total++; if (In_Service_Reg !== m_isr) begin bad++; $display("FAIL %s_isr got=%h exp=%h", tag, In_Service_Reg, m_isr); end
  endtask

  task automatic test_rotate();
    Vector_Base = 5'd3;
    serve_and_eoi(8'h04, 8'h04, "rot_ir2_a");
    serve_and_eoi(8'h05, 8'h01, "rot_05");
    serve_and_eoi(8'h04, 8'h04, "rot_ir2_b");
`ifdef AUTO_ROTATE_EN
    serve_and_eoi(8'h0C, 8'h08, "rot_0c");
`else
    serve_and_eoi(8'h0C, 8'h04, "rot_0c");
`endif
  endtask

  task automatic test_random();
    int w;
    logic [7:0] ec;
    logic [2:0] l3;
    logic [1:0] r;
    for (int it = 0; it < 40; it++) begin
      Vector_Base = 5'($urandom); Int_Req_Reg = 8'($urandom); Int_Mask = 8'($urandom); Auto_EOI = 1'($urandom);
      step();
      w = m_win();
      total++; if (INT !== (w >= 0)) begin bad++; $display("FAIL rnd_int it=%0d got=%b exp=%b", it, INT, w >= 0); end
      ec = (w >= 0) ? 8'd1 << w : 8'd0;
      l3 = (w >= 0) ? 3'(w) : 3'd7;
      handshake(c1, c2, i1, v, ie, de, n1, e2, ee);
      m_isr = m_isr | ec;
      total++; if (c1 !== ec || c2 !== 8'h00) begin bad++; $display("FAIL rnd_clr it=%0d got=%h/%h exp=%h/00", it, c1, c2, ec); end
      total++; if (i1 !== m_isr) begin bad++; $display("FAIL rnd_isr1 it=%0d got=%h exp=%h", it, i1, m_isr); end
      total++; if (v !== {Vector_Base, l3} || e2 !== 1'b1 || ee !== 1'b0 || de !== 8'h00) begin bad++; $display("FAIL rnd_vec it=%0d got=%h/%b/%h/%b exp=%h/1/00/0", it, v, e2, de, ee, {Vector_Base, l3}); end
      if (Auto_EOI && w >= 0) m_clear(w);
      total++; if (ie !== m_isr) begin bad++; $display("FAIL rnd_isr_end it=%0d got=%h exp=%h", it, ie, m_isr); end
      Int_Req_Reg = 8'h00;
      r = 2'($urandom);
      pulse_eoi(r[0], r[1], 3'($urandom));
      total++; if (In_Service_Reg !== m_isr) begin bad++; $display("FAIL rnd_eoi it=%0d got=%h exp=%h", it, In_Service_Reg, m_isr); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_nesting();
    test_aeoi_mask();
    test_spurious();
    test_reset_mid_ack2();
    test_rotate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
